hog_cell_feeder: RTL

//  Responder side of the HOG request/ready cell-fetch handshake. On each `request` pulse from the HOG front end,

---
 rtl/hog_feeder_pkg.sv | 34 +++
 rtl/hog_cell_addr_gen.sv | 53 +++++
 rtl/hog_cell_feeder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hog_feeder_pkg.sv
// Shared constants, window slot mapping and FSM state type for the HOG cell feeder.
// The optional zero-border mode is selected with HOG_FEEDER_ZERO_BORDER_EN.
package hog_feeder_pkg;

    localparam int CELL_S = 10;
    localparam int PIX_N  = CELL_S * CELL_S - 4;
    localparam int SLOT_W = 7;

    // Slot indices where the dropped corners shift the row-major position.
    localparam logic [SLOT_W-1:0] SLOT_ROW0_END  = 7'd8;
    localparam logic [SLOT_W-1:0] SLOT_ROW9_BEG  = 7'd88;
    localparam logic [SLOT_W-1:0] SLOT_LAST      = 7'd95;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

    function automatic logic [SLOT_W-1:0] slot_to_pos(input logic [SLOT_W-1:0] k);
        logic [SLOT_W-1:0] pos;
        if (k < SLOT_ROW0_END) begin
            pos = k + 7'd1;
        end else if (k < SLOT_ROW9_BEG) begin
            pos = k + 7'd2;
        end else begin
            pos = k + 7'd3;
        end
        return pos;
    endfunction

endpackage

// File: rtl/hog_cell_addr_gen.sv
// Maps a window slot of cell (cx,cy) to a clamped pixel RAM address plus an
// out-of-image flag (used by the HOG_FEEDER_ZERO_BORDER_EN build).
module hog_cell_addr_gen
    import hog_feeder_pkg::*;
#(
    parameter int CELL_X_N = 8,
    parameter int CELL_Y_N = 16,
    parameter int ADDR_W   = 13,
    parameter int CX_W     = $clog2(CELL_X_N),
    parameter int CY_W     = $clog2(CELL_Y_N)
) (
    input  logic [SLOT_W-1:0] slot,
    input  logic [CX_W-1:0]   cx,
    input  logic [CY_W-1:0]   cy,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    localparam int IMG_W = 8 * CELL_X_N;
    localparam int IMG_H = 8 * CELL_Y_N;
    localparam int XS_W  = $clog2(IMG_W + 2);
    localparam int YS_W  = $clog2(IMG_H + 2);

    logic [SLOT_W-1:0] pos_s;
    logic [3:0]        row_s;
    logic [3:0]        col_s;
    logic [XS_W-1:0]   xs_s;
    logic [XS_W-1:0]   xc_s;
    logic [YS_W-1:0]   ys_s;
    logic [YS_W-1:0]   yc_s;
    logic              x_lo_s;
    logic              x_hi_s;
    logic              y_lo_s;
    logic              y_hi_s;

    // xs/ys carry the image coordinate plus one so the -1 border stays unsigned.
    always_comb begin
        pos_s  = slot_to_pos(slot);
        row_s  = 4'(pos_s / 7'd10);
        col_s  = 4'(pos_s % 7'd10);
        xs_s   = XS_W'({cx, 3'b000}) + XS_W'(col_s);
        ys_s   = YS_W'({cy, 3'b000}) + YS_W'(row_s);
        x_lo_s = (xs_s == '0);
        x_hi_s = (xs_s == XS_W'(IMG_W + 1));
        y_lo_s = (ys_s == '0);
        y_hi_s = (ys_s == YS_W'(IMG_H + 1));
        xc_s   = x_lo_s ? '0 : (x_hi_s ? XS_W'(IMG_W - 1) : xs_s - XS_W'(1));
        yc_s   = y_lo_s ? '0 : (y_hi_s ? YS_W'(IMG_H - 1) : ys_s - YS_W'(1));
        addr   = ADDR_W'(yc_s) * ADDR_W'(IMG_W) + ADDR_W'(xc_s);
        oob    = x_lo_s | x_hi_s | y_lo_s | y_hi_s;
    end

endmodule

// File: rtl/hog_cell_feeder.sv
// Responder for the HOG cell-fetch handshake: streams 96 window pixels from the pixel RAM per request.
// Define HOG_FEEDER_ZERO_BORDER_EN to return 0 for out-of-image pixels instead of replicating edges.
module hog_cell_feeder
    import hog_feeder_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int CELL_X_N = 8,
    parameter int CELL_Y_N = 16,
    parameter int ADDR_W   = 13,
    parameter int CX_W     = $clog2(CELL_X_N),
    parameter int CY_W     = $clog2(CELL_Y_N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   request,
    output logic                   ready,
    output logic [PIX_W*PIX_N-1:0] i_data_fetch,
    output logic [CX_W-1:0]        cell_x,
    output logic [CY_W-1:0]        cell_y,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [PIX_W-1:0]       mem_rdata
);

    localparam int WIN_W = PIX_W * PIX_N;

    feeder_state_e     state_r;
    feeder_state_e     state_s;
    feeder_state_e     case_next_s;
    logic [SLOT_W-1:0] slot_r;
    logic [SLOT_W-1:0] gen_slot_s;
    logic [ADDR_W-1:0] gen_addr_s;
    logic              gen_oob_s;
    logic              rd_slot_s;
    logic [CX_W-1:0]   cx_r;
    logic [CY_W-1:0]   cy_r;
    logic              is_last_s;
    logic              pending_r;
    logic              cap_r;
    logic [PIX_W-1:0]  pix_in_s;
    logic [WIN_W-1:0]  shreg_r;
    logic [WIN_W-1:0]  shift_next_s;

    hog_cell_addr_gen #(
        .CELL_X_N (CELL_X_N),
        .CELL_Y_N (CELL_Y_N),
        .ADDR_W   (ADDR_W),
        .CX_W     (CX_W),
        .CY_W     (CY_W)
    ) u_addr_gen (
        .slot (gen_slot_s),
        .cx   (cx_r),
        .cy   (cy_r),
        .addr (gen_addr_s),
        .oob  (gen_oob_s)
    );

`ifdef HOG_FEEDER_ZERO_BORDER_EN
    logic issue_oob_r;
    logic oob_d_r;

    // Out-of-image flag travels with the read so the returning byte can be zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_oob_r <= 1'b0;
            oob_d_r     <= 1'b0;
        end else begin
            issue_oob_r <= gen_oob_s;
            oob_d_r     <= issue_oob_r;
        end
    end

    assign rd_slot_s = ~gen_oob_s;
    assign pix_in_s  = oob_d_r ? '0 : mem_rdata;
`else
    logic unused_oob_s;
    assign unused_oob_s = gen_oob_s;
    assign rd_slot_s    = 1'b1;
    assign pix_in_s     = mem_rdata;
`endif

    // Next state; the address generator always looks one slot ahead of the bus.
    always_comb begin
        case_next_s = state_r;
        case (state_r)
            ST_IDLE:  case_next_s = ST_IDLE;
            ST_WAIT:  case_next_s = (request | pending_r) ? ST_FETCH : ST_WAIT;
            ST_FETCH: case_next_s = (slot_r == SLOT_LAST) ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: case_next_s = ST_DONE;
            ST_DONE:  case_next_s = is_last_s ? ST_IDLE : ST_WAIT;
            default:  case_next_s = ST_IDLE;
        endcase
        state_s      = frame_start ? ST_WAIT : case_next_s;
        gen_slot_s   = (state_r == ST_FETCH) ? slot_r + 7'd1 : '0;
        is_last_s    = (cx_r == CX_W'(CELL_X_N - 1)) && (cy_r == CY_W'(CELL_Y_N - 1));
        shift_next_s = {pix_in_s, shreg_r[WIN_W-1:PIX_W]};
    end

    // State register and issue slot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            slot_r  <= '0;
        end else begin
            state_r <= state_s;
            slot_r  <= (state_r == ST_FETCH && state_s == ST_FETCH) ? slot_r + 7'd1 : '0;
        end
    end

    // Pixel RAM read port; cap_r marks the cycle the read data comes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            cap_r     <= 1'b0;
        end else begin
            if (state_s == ST_FETCH) begin
                mem_rd_en <= rd_slot_s;
                mem_addr  <= gen_addr_s;
            end else begin
                mem_rd_en <= 1'b0;
                mem_addr  <= mem_addr;
            end
            cap_r <= (state_r == ST_FETCH);
        end
    end

    // Window assembly: slot 0 enters first and ends up in the lowest byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= '0;
        end else if (cap_r) begin
            shreg_r <= shift_next_s;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Result outputs change only on entry to DONE; the final byte is merged in directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready        <= 1'b0;
            frame_done   <= 1'b0;
            i_data_fetch <= '0;
            cell_x       <= '0;
            cell_y       <= '0;
        end else if (state_s == ST_DONE) begin
            ready        <= 1'b1;
            frame_done   <= is_last_s;
            i_data_fetch <= shift_next_s;
            cell_x       <= cx_r;
            cell_y       <= cy_r;
        end else begin
            ready        <= 1'b0;
            frame_done   <= 1'b0;
            i_data_fetch <= i_data_fetch;
            cell_x       <= cell_x;
            cell_y       <= cell_y;
        end
    end

    // Cell raster counters, 1-deep request buffer and frame activity flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_r      <= '0;
            cy_r      <= '0;
            pending_r <= 1'b0;
            busy      <= 1'b0;
        end else if (frame_start) begin
            cx_r      <= '0;
            cy_r      <= '0;
            pending_r <= 1'b0;
            busy      <= 1'b1;
        end else begin
            busy <= (state_s != ST_IDLE);
            case (state_r)
                ST_DONE: begin
                    pending_r <= is_last_s ? 1'b0 : (pending_r | request);
                    if (cx_r == CX_W'(CELL_X_N - 1)) begin
                        cx_r <= '0;
                        cy_r <= is_last_s ? '0 : cy_r + CY_W'(1);
                    end else begin
                        cx_r <= cx_r + CX_W'(1);
                        cy_r <= cy_r;
                    end
                end
                ST_FETCH, ST_DRAIN: begin
                    pending_r <= pending_r | request;
                end
                default: begin
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
